// File: rtl/light_level_ctrl.sv
// light_level_ctrl: N-level light controller driven by up/down push-buttons.
// A press steps the level immediately; holding the button auto-repeats after
// REPEAT_DLY cycles, then every REPEAT_PER cycles. The ends either saturate or
// wrap (WRAP).
// Optional feature macro LIGHT_IDLE_OFF_EN: after IDLE_CYCLES cycles with no
// action, a lit output is forced back to level 0.
module light_level_ctrl #(
  parameter int unsigned LEVELS      = 8,
  parameter int unsigned WRAP        = 0,
  parameter int unsigned REPEAT_DLY  = 50,
  parameter int unsigned REPEAT_PER  = 10,
  parameter int unsigned IDLE_CYCLES = 1000,
  localparam int unsigned LW         = $clog2(LEVELS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          button_up,
  input  logic          button_down,
  output logic [LW-1:0] light,
  output logic          at_max,
  output logic          at_min,
  output logic          step_pulse
);

  localparam int unsigned DlyPer = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int unsigned CntMax = (DlyPer > IDLE_CYCLES) ? DlyPer : IDLE_CYCLES;
  localparam int unsigned CW     = $clog2(CntMax + 1);

  localparam logic [LW-1:0] MaxLvl = LW'(LEVELS - 1);

  typedef enum logic [1:0] {ActNone, ActUp, ActDn} action_e;
  typedef enum logic [1:0] {StIdle, StHold, StRepeat} state_e;

  action_e       act, act_q;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] light_q, light_d;
  logic          step_pulse_q;
  logic          press;
  logic          step;
  logic          idle_hit;

  // Decode the button pair into a single action; both or neither is no action.
  always_comb begin
    act = ActNone;
    if (button_up && !button_down) begin
      act = ActUp;
    end else if (!button_up && button_down) begin
      act = ActDn;
    end
  end

  // A press is any new UP/DN action, including a direct UP<->DN swap.
  assign press = (act != ActNone) && (act != act_q);

  // FSM state, repeat counter and previous action.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      act_q   <= ActNone;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act;
    end
  end

  // Next-state logic: step on press, then after the hold delay, then periodically.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step    = 1'b0;
    if (act == ActNone) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (press) begin
      step    = 1'b1;
      cnt_d   = '0;
      state_d = StHold;
    end else begin
      unique case (state_q)
        StHold: begin
          if (cnt_q == CW'(REPEAT_DLY - 1)) begin
            step    = 1'b1;
            cnt_d   = '0;
            state_d = StRepeat;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        StRepeat: begin
          if (cnt_q == CW'(REPEAT_PER - 1)) begin
            step  = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LIGHT_IDLE_OFF_EN
  logic [CW-1:0] idle_q, idle_d;

  // Idle counter runs only while nothing is pressed and the light is on.
  always_comb begin
    idle_d   = '0;
    idle_hit = 1'b0;
    if (act == ActNone && light_q != '0) begin
      if (idle_q == CW'(IDLE_CYCLES - 1)) begin
        idle_hit = 1'b1;
      end else begin
        idle_d = idle_q + CW'(1);
      end
    end
  end

  // Idle counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  assign idle_hit = 1'b0;
`endif

  // Output logic: next light level and end-of-range flags.
  always_comb begin
    light_d = light_q;
    if (step) begin
      if (act == ActUp) begin
        if (light_q != MaxLvl) begin
          light_d = light_q + LW'(1);
        end else if (WRAP != 0) begin
          light_d = '0;
        end
      end else begin
        if (light_q != '0) begin
          light_d = light_q - LW'(1);
        end else if (WRAP != 0) begin
          light_d = MaxLvl;
        end
      end
    end
    if (idle_hit) begin
      light_d = '0;
    end
    at_max = (light_q == MaxLvl);
    at_min = (light_q == '0);
  end

  // Level register; step_pulse flags any actual level change.
  always_ff @(posedge clk) begin
    if (rst) begin
      light_q      <= '0;
      step_pulse_q <= 1'b0;
    end else begin
      light_q      <= light_d;
      step_pulse_q <= (light_d != light_q);
    end
  end

  assign light      = light_q;
  assign step_pulse = step_pulse_q;

endmodule

// File: tb/tb_light_level_ctrl.sv
// Directed bench for light_level_ctrl: three instances (saturating 8-level,
// wrapping 8-level, saturating 5-level) share clock, reset and buttons.
module tb_light_level_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       up  = 1'b0;
  logic       dn  = 1'b0;
  logic [2:0] l0, lw, l5;
  logic       mx0, mn0, sp0, mxw, mnw, spw, mx5, mn5, sp5;

  int checks   = 0;
  int failures = 0;
  int np0, npw, np5;
  int max5;
  logic [11:0] mask;

  always #5 clk = ~clk;

  light_level_ctrl #(
    .LEVELS(8), .WRAP(0), .REPEAT_DLY(4), .REPEAT_PER(2), .IDLE_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .button_up(up), .button_down(dn),
    .light(l0), .at_max(mx0), .at_min(mn0), .step_pulse(sp0)
  );

  light_level_ctrl #(
    .LEVELS(8), .WRAP(1), .REPEAT_DLY(4), .REPEAT_PER(2), .IDLE_CYCLES(16)
  ) dut_w (
    .clk(clk), .rst(rst), .button_up(up), .button_down(dn),
    .light(lw), .at_max(mxw), .at_min(mnw), .step_pulse(spw)
  );

  light_level_ctrl #(
    .LEVELS(5), .WRAP(0), .REPEAT_DLY(4), .REPEAT_PER(2), .IDLE_CYCLES(16)
  ) dut_5 (
    .clk(clk), .rst(rst), .button_up(up), .button_down(dn),
    .light(l5), .at_max(mx5), .at_min(mn5), .step_pulse(sp5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock edge, then sample just after it.
  task automatic tick();
    @(posedge clk);
    #1;
    if (sp0) np0++;
    if (spw) npw++;
    if (sp5) np5++;
    if (int'(l5) > max5) max5 = int'(l5);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    up  = 1'b0;
    dn  = 1'b0;
    tick();
    tick();
    rst  = 1'b0;
    np0  = 0;
    npw  = 0;
    np5  = 0;
    max5 = 0;
  endtask

  task automatic press_up();
    up = 1'b1;
    tick();
    up = 1'b0;
    tick();
  endtask

  initial begin
    // Reset values, then a single-cycle UP pulse right after reset.
    rst = 1'b1;
    up  = 1'b1;
    tick();
    tick();
    check("rst_light", l0, 0);
    check("rst_at_min", mn0, 1);
    check("rst_at_max", mx0, 0);
    check("rst_pulse", sp0, 0);
    rst = 1'b0;
    tick();
    check("first_light", l0, 1);
    check("first_pulse", sp0, 1);
    check("first_at_min", mn0, 0);
    up = 1'b0;
    tick();
    check("first_hold", l0, 1);
    check("first_pulse_end", sp0, 0);

    // Hold UP 12 cycles: steps at 0,4,6,8,10.
    do_reset();
    up = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      mask[k] = sp0;
    end
    check("hold_mask", mask, 12'h551);
    check("hold_light", l0, 5);
    up  = 1'b0;
    np0 = 0;
    tick();
    tick();
    tick();
    check("release_light", l0, 5);
    check("release_pulses", np0, 0);
    up = 1'b1;
    tick();
    check("repress_light", l0, 6);
    up = 1'b0;
    tick();

    // Single presses up to and past the top.
    do_reset();
    repeat (6) press_up();
    check("six_sat", l0, 6);
    check("six_wrap", lw, 6);
    np0 = 0;
    npw = 0;
    repeat (8) press_up();
    check("sat_light", l0, 7);
    check("sat_at_max", mx0, 1);
    check("sat_pulses", np0, 1);
    check("wrap_light", lw, 6);
    check("wrap_pulses", npw, 8);

    // DN at level 0.
    do_reset();
    dn = 1'b1;
    tick();
    check("dn0_sat_light", l0, 0);
    check("dn0_sat_pulse", sp0, 0);
    check("dn0_wrap_light", lw, 7);
    check("dn0_wrap_pulse", spw, 1);
    check("dn0_wrap_max", mxw, 1);
    dn = 1'b0;
    tick();

    // Both buttons, then a direct UP->DN swap.
    do_reset();
    repeat (3) press_up();
    np0 = 0;
    up  = 1'b1;
    dn  = 1'b1;
    repeat (10) tick();
    check("both_light", l0, 3);
    check("both_pulses", np0, 0);
    dn = 1'b0;
    tick();
    check("swap_up1", l0, 4);
    tick();
    check("swap_up2", l0, 4);
    up = 1'b0;
    dn = 1'b1;
    tick();
    check("swap_dn", l0, 3);
    check("swap_dn_pulse", sp0, 1);
    dn = 1'b0;
    tick();

    // Non-power-of-2 level count under a long hold.
    do_reset();
    up = 1'b1;
    repeat (20) tick();
    up = 1'b0;
    check("l5_max_seen", max5, 4);
    check("l5_light", l5, 4);
    check("l5_at_max", mx5, 1);
    check("l8_long_hold", l0, 7);
    tick();

    // Idle behaviour after release at level 5.
    do_reset();
    repeat (4) press_up();
    up = 1'b1;
    tick();
    check("idle_start", l0, 5);
    np0 = 0;
    up  = 1'b0;
    repeat (15) tick();
    check("idle_15", l0, 5);
    check("idle_15_pulses", np0, 0);
    tick();
`ifdef LIGHT_IDLE_OFF_EN
    check("idle_16", l0, 0);
    check("idle_16_pulse", sp0, 1);
    check("idle_16_min", mn0, 1);
`else
    check("idle_16", l0, 5);
    check("idle_16_pulse", sp0, 0);
`endif
    repeat (20) tick();
`ifdef LIGHT_IDLE_OFF_EN
    check("idle_after", l0, 0);
    check("idle_after_pulses", np0, 1);
`else
    check("idle_after", l0, 5);
    check("idle_after_pulses", np0, 0);
`endif

    // A press part-way through the idle count restarts it.
    do_reset();
    repeat (4) press_up();
    up = 1'b1;
    tick();
    up = 1'b0;
    repeat (10) tick();
    up = 1'b1;
    tick();
    check("restart_press", l0, 6);
    up = 1'b0;
    repeat (15) tick();
    check("restart_15", l0, 6);
    tick();
`ifdef LIGHT_IDLE_OFF_EN
    check("restart_16", l0, 0);
`else
    check("restart_16", l0, 6);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
